// File: rtl/bg_addr_gen.sv
// Scrolling background address generator: maps raster position plus a frame-latched
// scroll offset to a 640-wide ROM index. Define BG_VSCROLL_EN to add vertical scrolling.
module bg_addr_gen #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int ROM_LAT  = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        pixel_valid,
  input  logic        hs_in,
  input  logic        vs_in,
  input  logic [9:0]  scroll_x_in,
`ifdef BG_VSCROLL_EN
  input  logic [8:0]  scroll_y_in,
`endif
  input  logic        scroll_req,
  output logic        scroll_ack,
  output logic [19:0] background_address,
  output logic        addr_valid,
  output logic        de_out,
  output logic        hs_out,
  output logic        vs_out
);

  localparam int          DLY    = 1 + ROM_LAT;
  localparam logic [10:0] H_LIM  = 11'(H_ACTIVE);
  localparam logic [10:0] V_LIM  = 11'(V_ACTIVE);
  localparam logic [9:0]  X_FULL = 10'd640;
`ifdef BG_VSCROLL_EN
  localparam logic [8:0]  Y_FULL = 9'd480;
`endif

  typedef enum logic [1:0] {IDLE, PENDING, ACK} state_t;

  function automatic logic [9:0] wrap_sum(input logic [10:0] sum, input logic [10:0] lim);
    logic [10:0] t;
    t = (sum >= lim) ? sum - lim : sum;
    return t[9:0];
  endfunction

  function automatic logic [9:0] reduce_x(input logic [9:0] v);
    return (v >= X_FULL) ? v - X_FULL : v;
  endfunction

  state_t       state_q, state_d;
  logic         ack_q, ack_d;
  logic         fs_prev_q, pix_start, frame_start;
  logic [9:0]   sx_pend_q, sx_pend_d, sx_act_q, sx_act_d;
  logic [19:0]  addr_p1_q, addr_p1_d;
  logic         vld_p1_q, vld_p1_d;
  logic [2:0]   dly_q [DLY];
  logic [2:0]   dly_d [DLY];
  logic         in_range;
  logic [9:0]   col, row;
  logic [19:0]  row_w;
`ifdef BG_VSCROLL_EN
  logic [8:0]   sy_pend_q, sy_pend_d, sy_act_q, sy_act_d;
`endif

  always_comb begin
    pix_start   = pixel_valid && (DrawX == 10'd0) && (DrawY == 10'd0);
    frame_start = pix_start && !fs_prev_q;
    state_d     = state_q;
    ack_d       = ack_q;
    sx_pend_d   = sx_pend_q;
    sx_act_d    = sx_act_q;
`ifdef BG_VSCROLL_EN
    sy_pend_d   = sy_pend_q;
    sy_act_d    = sy_act_q;
`endif
    case (state_q)
      IDLE: if (scroll_req) begin
        sx_pend_d = reduce_x(scroll_x_in);
`ifdef BG_VSCROLL_EN
        sy_pend_d = (scroll_y_in >= Y_FULL) ? scroll_y_in - Y_FULL : scroll_y_in;
`endif
        state_d   = PENDING;
      end
      // New offset only lands on a frame boundary so a frame never tears.
      PENDING: if (frame_start) begin
        sx_act_d = sx_pend_q;
`ifdef BG_VSCROLL_EN
        sy_act_d = sy_pend_q;
`endif
        state_d  = ACK;
        ack_d    = 1'b1;
      end
      ACK: if (!scroll_req) begin
        state_d = IDLE;
        ack_d   = 1'b0;
      end
      default: begin
        state_d = IDLE;
        ack_d   = 1'b0;
      end
    endcase
  end

  always_comb begin
    in_range = pixel_valid && ({1'b0, DrawX} < H_LIM) && ({1'b0, DrawY} < V_LIM);
    col      = wrap_sum({1'b0, DrawX} + {1'b0, sx_act_q}, H_LIM);
`ifdef BG_VSCROLL_EN
    row      = wrap_sum({1'b0, DrawY} + {2'b0, sy_act_q}, V_LIM);
`else
    row      = DrawY;
`endif
    row_w     = {10'd0, row};
    addr_p1_d = in_range ? (row_w << 9) + (row_w << 7) + {10'd0, col} : 20'd0;
    vld_p1_d  = in_range;
    dly_d[0]  = {pixel_valid, hs_in, vs_in};
    for (int i = 1; i < DLY; i++) dly_d[i] = dly_q[i-1];
  end

  // Stage boundary: address/valid registered; sync bits ride a 1+ROM_LAT delay line.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      ack_q     <= 1'b0;
      fs_prev_q <= 1'b0;
      sx_pend_q <= '0;
      sx_act_q  <= '0;
`ifdef BG_VSCROLL_EN
      sy_pend_q <= '0;
      sy_act_q  <= '0;
`endif
      addr_p1_q <= '0;
      vld_p1_q  <= 1'b0;
      for (int i = 0; i < DLY; i++) dly_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      ack_q     <= ack_d;
      fs_prev_q <= pix_start;
      sx_pend_q <= sx_pend_d;
      sx_act_q  <= sx_act_d;
`ifdef BG_VSCROLL_EN
      sy_pend_q <= sy_pend_d;
      sy_act_q  <= sy_act_d;
`endif
      addr_p1_q <= addr_p1_d;
      vld_p1_q  <= vld_p1_d;
      for (int i = 0; i < DLY; i++) dly_q[i] <= dly_d[i];
    end
  end

  assign scroll_ack         = ack_q;
  assign background_address = addr_p1_q;
  assign addr_valid         = vld_p1_q;
  assign de_out             = dly_q[DLY-1][2];
  assign hs_out             = dly_q[DLY-1][1];
  assign vs_out             = dly_q[DLY-1][0];

endmodule

// File: tb/tb_bg_addr_gen.sv
// Self-checking bench for bg_addr_gen: randomized pixels against an arithmetic model
// of address = row*640 + (x+scroll)%640, plus scroll handshake and reset scenarios.
module tb_bg_addr_gen;
  logic        Clk = 1'b0;
  logic        Reset, pixel_valid, hs_in, vs_in, scroll_req;
  logic [9:0]  DrawX, DrawY, scroll_x_in;
  logic        scroll_ack, addr_valid, de_out, hs_out, vs_out;
  logic [19:0] background_address;
`ifdef BG_VSCROLL_EN
  logic [8:0]  scroll_y_in = '0;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int m_act   = 0;

  always #5 Clk = ~Clk;

  bg_addr_gen dut (
    .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY), .pixel_valid(pixel_valid),
    .hs_in(hs_in), .vs_in(vs_in), .scroll_x_in(scroll_x_in),
`ifdef BG_VSCROLL_EN
    .scroll_y_in(scroll_y_in),
`endif
    .scroll_req(scroll_req), .scroll_ack(scroll_ack),
    .background_address(background_address), .addr_valid(addr_valid),
    .de_out(de_out), .hs_out(hs_out), .vs_out(vs_out));

  function automatic int ref_addr(int x, int y, bit v, int act);
    if (!v || x >= 640 || y >= 480) return 0;
    return y * 640 + (x + act) % 640;
  endfunction

  task automatic tick();
    @(posedge Clk); #1;
  endtask

  task automatic drive(int x, int y, bit v);
    DrawX = 10'(x); DrawY = 10'(y); pixel_valid = v;
  endtask

  task automatic test_reset();
    Reset = 1; scroll_req = 0; scroll_x_in = 0; hs_in = 1; vs_in = 1;
    drive(5, 5, 1);
    tick(); tick();
    n_tests++; if (background_address !== 20'd0) begin n_fail++; $display("FAIL reset_addr got %0d exp 0", background_address); end
    n_tests++; if (addr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", addr_valid); end
    n_tests++; if (scroll_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack got %b exp 0", scroll_ack); end
    n_tests++; if ({de_out, hs_out, vs_out} !== 3'b000) begin n_fail++; $display("FAIL reset_sync got %b exp 000", {de_out, hs_out, vs_out}); end
    Reset = 0; hs_in = 0; vs_in = 0; m_act = 0;
  endtask

  task automatic test_basic();
    drive(7, 7, 0); tick();
    drive(5, 2, 1); hs_in = 1; tick();
    n_tests++; if (background_address !== 20'd1285) begin n_fail++; $display("FAIL basic_addr got %0d exp 1285", background_address); end
    n_tests++; if (addr_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got %b exp 1", addr_valid); end
    n_tests++; if (de_out !== 1'b0) begin n_fail++; $display("FAIL basic_de_early got %b exp 0", de_out); end
    drive(6, 2, 0); hs_in = 0; tick();
    n_tests++; if ({de_out, hs_out, vs_out} !== 3'b110) begin n_fail++; $display("FAIL basic_sync_delay got %b exp 110", {de_out, hs_out, vs_out}); end
    n_tests++; if (addr_valid !== 1'b0) begin n_fail++; $display("FAIL basic_invalid got %b exp 0", addr_valid); end
    tick();
    n_tests++; if (de_out !== 1'b0) begin n_fail++; $display("FAIL basic_de_late got %b exp 0", de_out); end
  endtask

  task automatic test_random();
    bit pv = 0, ph = 0, ps = 0;
    for (int i = 0; i < 60; i++) begin
      int x, y, e; bit v;
      x = $urandom_range(0, 700); y = $urandom_range(1, 520); v = ($urandom_range(0, 3) != 0);
      drive(x, y, v); hs_in = $urandom_range(0, 1); vs_in = $urandom_range(0, 1);
      tick();
      e = ref_addr(x, y, v, m_act);
      n_tests++; if (background_address !== 20'(e)) begin n_fail++; $display("FAIL rand_addr x=%0d y=%0d got %0d exp %0d", x, y, background_address, e); end
      n_tests++; if (addr_valid !== (e != 0 || (v && x < 640 && y < 480))) begin n_fail++; $display("FAIL rand_valid got %b", addr_valid); end
      n_tests++; if ({de_out, hs_out, vs_out} !== {pv, ph, ps}) begin n_fail++; $display("FAIL rand_sync got %b exp %b", {de_out, hs_out, vs_out}, {pv, ph, ps}); end
      pv = v; ph = hs_in; ps = vs_in;
    end
    hs_in = 0; vs_in = 0;
  endtask

  task automatic test_handshake();
    int x, y;
    drive(100, 50, 1); scroll_x_in = 700; scroll_req = 1; tick();
    n_tests++; if (background_address !== 20'd32100) begin n_fail++; $display("FAIL hs_pre_addr got %0d exp 32100", background_address); end
    n_tests++; if (scroll_ack !== 1'b0) begin n_fail++; $display("FAIL hs_pending_ack got %b exp 0", scroll_ack); end
    scroll_x_in = 5;
    for (int i = 0; i < 5; i++) begin
      x = $urandom_range(1, 639); y = $urandom_range(1, 479);
      drive(x, y, 1); tick();
      n_tests++; if (background_address !== 20'(ref_addr(x, y, 1, m_act))) begin n_fail++; $display("FAIL hs_midframe got %0d exp %0d", background_address, ref_addr(x, y, 1, m_act)); end
    end
    drive(0, 0, 1); tick();
    n_tests++; if (background_address !== 20'd0) begin n_fail++; $display("FAIL hs_fs_old got %0d exp 0", background_address); end
    n_tests++; if (scroll_ack !== 1'b1) begin n_fail++; $display("FAIL hs_ack_rise got %b exp 1", scroll_ack); end
    m_act = 60;
    drive(1, 0, 1); tick();
    n_tests++; if (background_address !== 20'd61) begin n_fail++; $display("FAIL hs_new_scroll got %0d exp 61", background_address); end
    for (int i = 0; i < 4; i++) begin
      x = $urandom_range(0, 639); y = $urandom_range(1, 479);
      drive(x, y, 1); tick();
      n_tests++; if (background_address !== 20'(ref_addr(x, y, 1, m_act))) begin n_fail++; $display("FAIL hs_frame_addr got %0d exp %0d", background_address, ref_addr(x, y, 1, m_act)); end
      n_tests++; if (scroll_ack !== 1'b1) begin n_fail++; $display("FAIL hs_ack_hold got %b exp 1", scroll_ack); end
    end
    scroll_req = 0; drive(20, 20, 1); tick();
    n_tests++; if (scroll_ack !== 1'b0) begin n_fail++; $display("FAIL hs_ack_drop got %b exp 0", scroll_ack); end
  endtask

  task automatic test_wrap();
    int x, y;
    scroll_x_in = 600; scroll_req = 1; drive(50, 10, 1); tick();
    drive(0, 0, 1); tick();
    n_tests++; if (scroll_ack !== 1'b1) begin n_fail++; $display("FAIL wrap_ack got %b exp 1", scroll_ack); end
    m_act = 600; scroll_req = 0;
    drive(100, 0, 1); tick();
    n_tests++; if (background_address !== 20'd60) begin n_fail++; $display("FAIL wrap_addr got %0d exp 60", background_address); end
    n_tests++; if (scroll_ack !== 1'b0) begin n_fail++; $display("FAIL wrap_ack_drop got %b exp 0", scroll_ack); end
    drive(39, 0, 1); tick();
    n_tests++; if (background_address !== 20'd639) begin n_fail++; $display("FAIL wrap_edge_hi got %0d exp 639", background_address); end
    drive(40, 0, 1); tick();
    n_tests++; if (background_address !== 20'd0) begin n_fail++; $display("FAIL wrap_edge_lo got %0d exp 0", background_address); end
    for (int i = 0; i < 20; i++) begin
      x = $urandom_range(0, 639); y = $urandom_range(1, 479);
      drive(x, y, 1); tick();
      n_tests++; if (background_address !== 20'(ref_addr(x, y, 1, m_act))) begin n_fail++; $display("FAIL wrap_rand got %0d exp %0d", background_address, ref_addr(x, y, 1, m_act)); end
    end
  endtask

  task automatic test_same_cycle();
    drive(9, 9, 1); tick();
    scroll_x_in = 10; scroll_req = 1; drive(0, 0, 1); tick();
    n_tests++; if (background_address !== 20'd600) begin n_fail++; $display("FAIL same_fs_addr got %0d exp 600", background_address); end
    scroll_x_in = 33; drive(3, 0, 1); tick();
    n_tests++; if (background_address !== 20'd603) begin n_fail++; $display("FAIL same_not_applied got %0d exp 603", background_address); end
    n_tests++; if (scroll_ack !== 1'b0) begin n_fail++; $display("FAIL same_ack_early got %b exp 0", scroll_ack); end
    drive(0, 0, 1); tick();
    n_tests++; if (background_address !== 20'd600) begin n_fail++; $display("FAIL same_fs2_addr got %0d exp 600", background_address); end
    n_tests++; if (scroll_ack !== 1'b1) begin n_fail++; $display("FAIL same_ack got %b exp 1", scroll_ack); end
    m_act = 10;
    drive(3, 0, 1); tick();
    n_tests++; if (background_address !== 20'd13) begin n_fail++; $display("FAIL same_applied got %0d exp 13", background_address); end
    scroll_req = 0; drive(4, 0, 1); tick();
    n_tests++; if (scroll_ack !== 1'b0) begin n_fail++; $display("FAIL same_ack_drop got %b exp 0", scroll_ack); end
    n_tests++; if (background_address !== 20'd14) begin n_fail++; $display("FAIL same_after got %0d exp 14", background_address); end
  endtask

  task automatic test_reset_pending();
    scroll_x_in = 300; scroll_req = 1; drive(5, 5, 1); tick();
    Reset = 1; scroll_req = 0; tick();
    n_tests++; if (scroll_ack !== 1'b0) begin n_fail++; $display("FAIL rstp_ack got %b exp 0", scroll_ack); end
    n_tests++; if (addr_valid !== 1'b0) begin n_fail++; $display("FAIL rstp_valid got %b exp 0", addr_valid); end
    Reset = 0; m_act = 0;
    drive(2, 2, 1); tick();
    drive(0, 0, 1); tick();
    n_tests++; if (scroll_ack !== 1'b0) begin n_fail++; $display("FAIL rstp_no_ack got %b exp 0", scroll_ack); end
    drive(7, 0, 1); tick();
    n_tests++; if (background_address !== 20'd7) begin n_fail++; $display("FAIL rstp_act_cleared got %0d exp 7", background_address); end
  endtask

  task automatic test_range();
    drive(100, 480, 1); tick();
    n_tests++; if ({addr_valid, background_address} !== 21'd0) begin n_fail++; $display("FAIL range_y480 got %b/%0d exp 0/0", addr_valid, background_address); end
    drive(640, 3, 1); tick();
    n_tests++; if ({addr_valid, background_address} !== 21'd0) begin n_fail++; $display("FAIL range_x640 got %b/%0d exp 0/0", addr_valid, background_address); end
    drive(639, 479, 1); tick();
    n_tests++; if (background_address !== 20'd307199 || addr_valid !== 1'b1) begin n_fail++; $display("FAIL range_last got %b/%0d exp 1/307199", addr_valid, background_address); end
    drive(0, 1, 0); tick();
    n_tests++; if ({addr_valid, background_address} !== 21'd0) begin n_fail++; $display("FAIL range_invalid got %b/%0d exp 0/0", addr_valid, background_address); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random();
    test_handshake();
    test_wrap();
    test_same_cycle();
    test_reset_pending();
    test_range();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/bg_addr_gen.md
BG_ADDR_GEN -- requirements
Module: bg_addr_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, meaning visible pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 480, meaning visible lines per frame.
REQ-003 SHALL have parameter ROM_LAT, default 1, meaning downstream ROM read latency in cycles.
REQ-004 SHALL have port Clk  input  1  pixel clock, one pixel per cycle; single clock domain.
REQ-005 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have ports DrawX  input  10  and DrawY  input  10, the current raster column and row.
REQ-007 SHALL have port pixel_valid  input  1  high during the visible region.
REQ-008 SHALL have ports hs_in, vs_in  input  1 each, raw sync from the VGA controller.
REQ-009 SHALL have port scroll_x_in  input  10  requested horizontal scroll.
REQ-010 SHALL have ports scroll_req  input  1  and scroll_ack  output  1, a 4-phase scroll-update handshake.
REQ-011 SHALL have port background_address  output  20  pixel index into the 640x480 background ROM.
REQ-012 SHALL have port addr_valid  output  1  high when background_address is meaningful.
REQ-013 SHALL have ports de_out, hs_out, vs_out  output  1 each, the inputs delayed to align with ROM data.

Function
REQ-014 SHALL register background_address and addr_valid 1 cycle after DrawX/DrawY/pixel_valid are sampled.
REQ-015 SHALL compute col = (DrawX + scroll_x_act) mod H_ACTIVE using one conditional subtract, with no divider.
REQ-016 SHALL compute address = row*640 + col using (row<<9)+(row<<7)+col, with the result 20 bits wide; row = DrawY.
REQ-017 SHALL output address 0 with addr_valid=0 when pixel_valid=0, DrawX>=H_ACTIVE, or DrawY>=V_ACTIVE.
REQ-018 SHALL delay pixel_valid, hs_in and vs_in by 1+ROM_LAT cycles (2 at default) to produce de_out, hs_out and vs_out.
REQ-019 SHALL define frame_start as the rising edge of (pixel_valid && DrawX==0 && DrawY==0), detected with a registered previous value.
REQ-020 SHALL implement the handshake FSM with states IDLE, PENDING and ACK.
REQ-021 SHALL, in IDLE with scroll_req=1, capture scroll_x_in into scroll_x_pend (reduced by 640 if >=640) and move to PENDING.
REQ-022 SHALL, in PENDING at frame_start, copy scroll_x_pend to scroll_x_act, then move to ACK on the next cycle.
REQ-023 SHALL hold scroll_ack=1 throughout ACK and return to IDLE in the cycle after scroll_req is sampled low.
REQ-024 SHALL use the old scroll_x_act for the frame_start pixel itself, with the new value first affecting the pixel after it; the new value is in effect for all subsequent pixels of the frame.
REQ-025 SHALL, when scroll_req rises in the same cycle as frame_start while in IDLE, capture the request and apply it at the following frame_start.
REQ-026 SHALL ignore scroll_x_in changes while in PENDING or ACK.
REQ-027 SHALL keep scroll_x_act constant within a frame, so there is no mid-frame tearing.

Reset
REQ-028 SHALL, when Reset=1 at a clock edge, set background_address=0, addr_valid=0, de_out/hs_out/vs_out=0, scroll_ack=0, scroll_x_act=0, scroll_x_pend=0, FSM=IDLE and the frame_start history=0.
REQ-029 SHALL give Reset priority over all simultaneous events, aborting any pending handshake mid-operation; the requester must re-issue it.

Configuration
REQ-030 SHALL, when macro BG_VSCROLL_EN is defined, add port scroll_y_in  input  9, captured and applied alongside scroll_x, with row = (DrawY + scroll_y_act) mod V_ACTIVE via one conditional subtract.
REQ-031 SHALL, when BG_VSCROLL_EN is undefined, omit scroll_y_in and scroll_y registers entirely and use row = DrawY.

Verification
REQ-032 SHALL cover: scroll 0, DrawX=5, DrawY=2, pixel_valid=1 -> background_address=1285, addr_valid=1 one cycle later; de_out high two cycles later.
REQ-033 SHALL cover: scroll_x_act=600, DrawX=100, DrawY=0 -> address 60, showing horizontal wrap.
REQ-034 SHALL cover: scroll_req with scroll_x_in=700 mid-frame -> state PENDING, scroll_x_pend=60; at the next frame_start scroll_x_act=60; scroll_ack high until req drops, then IDLE.
REQ-035 SHALL cover: pixel_valid=0 or DrawY=480 -> address 0, addr_valid 0; Reset asserted in PENDING -> IDLE, scroll_ack 0, scroll_x_act 0 the next cycle.
REQ-036 SHALL cover: with BG_VSCROLL_EN, scroll_y=470, DrawY=20, DrawX=0 -> row 10, address 6400.
